// File: rtl/sbox_bank_prog_if.sv
`timescale 1ns/1ps
// Lookup handshake bundle for sbox_bank_prog.
//   in_valid / in_ready / in_word    : request side, one N_CH*IN_W word per transfer
//   out_valid / out_ready / out_word : result side, one N_CH*OUT_W word per transfer
// master = the requester/consumer, slave = the S-box bank.
interface sbox_bank_prog_if #(
  parameter int N_CH  = 8,
  parameter int IN_W  = 6,
  parameter int OUT_W = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N_CH*IN_W-1:0]    in_word;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_CH*OUT_W-1:0]   out_word;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word
  );
endinterface

// File: rtl/sbox_bank_prog.sv
`timescale 1ns/1ps
// sbox_bank_prog
//   Bank of N_CH run-time programmable S-boxes (IN_W -> OUT_W each), evaluated
//   in parallel with one registered output stage. Tables are written in LOAD,
//   looked up in RUN.
// Ports
//   clk, rst_n        : rising-edge clock, synchronous active-low reset
//   cfg_we/ch/addr/data: table write port (LOAD only, out-of-range channel ignored)
//   cfg_done          : LOAD -> RUN
//   cfg_reload        : RUN -> LOAD when the pipeline is empty and idle
//   bus (slave)       : in_valid/in_ready/in_word request, out_valid/out_ready/out_word result
//   running           : high in RUN
//   lookup_cnt        : accepted lookups, free-running 32-bit wrap
module sbox_bank_prog #(
  parameter int N_CH  = 8,
  parameter int IN_W  = 6,
  parameter int OUT_W = 2,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [IN_W-1:0]   cfg_addr,
  input  logic [OUT_W-1:0]  cfg_data,
  input  logic              cfg_done,
  input  logic              cfg_reload,
  sbox_bank_prog_if.slave   bus,
  output logic              running,
  output logic [31:0]       lookup_cnt
);

  localparam int DEPTH = 2**IN_W;

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t                  state;
  logic [OUT_W-1:0]        tbl [N_CH][DEPTH];
  logic                    out_valid_q;
  logic [N_CH*OUT_W-1:0]   out_word_q;
  logic [31:0]             lookup_cnt_q;
  logic [N_CH*OUT_W-1:0]   lookup_word;
  logic                    fire;
  logic                    ch_ok;

  // Parallel table read for every channel from its own slice of in_word.
  always_comb begin
    // NOTE: default assignment first so every path drives the full vector and no latch is inferred.
    lookup_word = '0;
    for (int c = 0; c < N_CH; c++) begin
      lookup_word[c*OUT_W +: OUT_W] = tbl[c][bus.in_word[c*IN_W +: IN_W]];
    end
  end

  // cfg_ch can encode values past the last channel when N_CH is not a power of two.
  assign ch_ok = (int'(cfg_ch) < N_CH);

  // A new request is taken whenever the output register is free or being drained this cycle.
  assign bus.in_ready  = (state == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign fire          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign running       = (state == ST_RUN);
  assign lookup_cnt    = lookup_cnt_q;

  // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_LOAD;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      lookup_cnt_q <= '0;
      // NOTE: the tables are flops, not RAM, because reset must return every entry to zero.
      for (int c = 0; c < N_CH; c++) begin
        for (int a = 0; a < DEPTH; a++) begin
          tbl[c][a] <= '0;
        end
      end
    end else begin
      case (state)
        ST_LOAD: begin
          // A write coinciding with cfg_done still lands before RUN starts.
          if (cfg_we && ch_ok) begin
            tbl[cfg_ch][cfg_addr] <= cfg_data;
          end
          if (cfg_done) begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (fire) begin
            out_word_q   <= lookup_word;
            out_valid_q  <= 1'b1;
            lookup_cnt_q <= lookup_cnt_q + 32'd1;
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_q  <= 1'b0;
          end
          // Reload only from a fully idle pipeline; otherwise the request is simply dropped.
          if (cfg_reload && !out_valid_q && !fire) begin
            state <= ST_LOAD;
          end
        end

        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_bank_prog.sv
`timescale 1ns/1ps
module tb_sbox_bank_prog;

  localparam int N_CH  = 8;
  localparam int IN_W  = 6;
  localparam int OUT_W = 2;
  // Second instance with a channel count whose index field can express out-of-range channels.
  localparam int N_CH2 = 5;

  logic clk = 1'b0;
  logic rst_n;

  logic        cfg_we, cfg_done, cfg_reload;
  logic [2:0]  cfg_ch;
  logic [5:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        running;
  logic [31:0] lookup_cnt;

  logic        cfg2_we, cfg2_done, cfg2_reload;
  logic [2:0]  cfg2_ch;
  logic [5:0]  cfg2_addr;
  logic [1:0]  cfg2_data;
  logic        running2;
  logic [31:0] lookup_cnt2;

  sbox_bank_prog_if #(.N_CH(N_CH),  .IN_W(IN_W), .OUT_W(OUT_W)) bus  ();
  sbox_bank_prog_if #(.N_CH(N_CH2), .IN_W(IN_W), .OUT_W(OUT_W)) bus2 ();

  sbox_bank_prog #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_done(cfg_done), .cfg_reload(cfg_reload),
    .bus(bus), .running(running), .lookup_cnt(lookup_cnt)
  );

  sbox_bank_prog #(.N_CH(N_CH2), .IN_W(IN_W), .OUT_W(OUT_W)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg2_we), .cfg_ch(cfg2_ch), .cfg_addr(cfg2_addr), .cfg_data(cfg2_data),
    .cfg_done(cfg2_done), .cfg_reload(cfg2_reload),
    .bus(bus2), .running(running2), .lookup_cnt(lookup_cnt2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  model [N_CH][64];
  logic [1:0]  s7 [64];
  logic [15:0] sb [$];
  logic [31:0] exp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_lookup(input logic [47:0] w);
    logic [15:0] r;
    r = '0;
    for (int c = 0; c < N_CH; c++) r[c*2 +: 2] = model[c][w[c*6 +: 6]];
    return r;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < N_CH; c++)
      for (int a = 0; a < 64; a++) model[c][a] = 2'd0;
  endtask

  // One write on the main bank; 'takes' says whether the bank should honour it.
  task automatic cfg_write(input int ch, input int addr, input int data, input bit done, input bit takes);
    cfg_we   = 1'b1;
    cfg_ch   = 3'(ch);
    cfg_addr = 6'(addr);
    cfg_data = 2'(data);
    cfg_done = done;
    step();
    cfg_we   = 1'b0;
    cfg_done = 1'b0;
    if (takes) model[ch][addr] = 2'(data);
  endtask

  // Request with channel 0 set to idx and other channels random.
  task automatic drive(input logic [5:0] idx);
    bus.in_word      = 48'({$urandom(), $urandom()});
    bus.in_word[5:0] = idx;
    bus.in_valid     = 1'b1;
  endtask

  // Scoreboard: push at acceptance, pop at result transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        assert (sb.size() != 0) else begin
          n_errors++;
          $error("FAIL sb_underflow: observed word %0h expected none pending", bus.out_word);
        end
        if (sb.size() != 0) check("sb_word", bus.out_word, sb.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model_lookup(bus.in_word));
        exp_cnt = exp_cnt + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] t2_idx [5];
    logic [1:0] t2_exp [5];
    logic [5:0] t5_idx [3];
    logic [1:0] t5_exp [3];
    t2_idx = '{6'd0, 6'd1, 6'd6, 6'd7, 6'd63};
    t2_exp = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd2};
    t5_idx = '{6'd1, 6'd6, 6'd7};
    t5_exp = '{2'd2, 2'd2, 2'd1};

    // S7 table: entries pinned at the exercised indices, filler elsewhere.
    for (int i = 0; i < 64; i++) s7[i] = 2'((i * 7 + (i >> 2)) % 4);
    s7[0] = 2'd0; s7[1] = 2'd3; s7[6] = 2'd2; s7[7] = 2'd1; s7[63] = 2'd2;

    clear_model();
    rst_n = 1'b0;
    cfg_we = 0; cfg_done = 0; cfg_reload = 0; cfg_ch = 0; cfg_addr = 0; cfg_data = 0;
    cfg2_we = 0; cfg2_done = 0; cfg2_reload = 0; cfg2_ch = 0; cfg2_addr = 0; cfg2_data = 0;
    bus.in_valid = 0; bus.in_word = '0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_word = '0; bus2.out_ready = 0;
    step();
    step();

    // 1: reset state, request ignored while in LOAD
    rst_n = 1'b1;
    drive(6'd5);
    step();
    check("t1_in_ready", bus.in_ready, 0);
    check("t1_out_valid", bus.out_valid, 0);
    check("t1_out_word", bus.out_word, 0);
    check("t1_lookup_cnt", lookup_cnt, 0);
    check("t1_running", running, 0);
    bus.in_valid = 1'b0;

    // 2: load S7 into ch0, zeros elsewhere; last entry written together with cfg_done
    for (int c = 0; c < N_CH; c++)
      for (int a = 0; a < 64; a++)
        cfg_write(c, a, (c == 0 && a != 63) ? int'(s7[a]) : 0, 1'b0, 1'b1);
    cfg_write(0, 63, int'(s7[63]), 1'b1, 1'b1);
    check("t2_running", running, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(t2_idx[i]);
      step();
      check("t2_out_valid", bus.out_valid, 1);
      check("t2_ch0", bus.out_word, {14'd0, t2_exp[i]});
    end
    bus.in_valid = 1'b0;
    step();
    check("t2_drained", bus.out_valid, 0);
    check("t2_cnt", lookup_cnt, 5);

    // 3: backpressure with a second request waiting
    bus.out_ready = 1'b0;
    drive(6'd7);
    step();
    drive(6'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_in_ready", bus.in_ready, 0);
      check("t3_hold", bus.out_word, 16'h0001);
      check("t3_cnt", lookup_cnt, 6);
    end
    bus.out_ready = 1'b1;
    step();
    check("t3_next_valid", bus.out_valid, 1);
    check("t3_next_word", bus.out_word, 16'h0002);
    check("t3_cnt_after", lookup_cnt, 7);
    bus.in_valid = 1'b0;
    step();

    // 4: table write attempted in RUN is ignored
    cfg_write(0, 1, 0, 1'b0, 1'b0);
    drive(6'd1);
    step();
    check("t4_ro", bus.out_word, 16'h0003);
    bus.in_valid = 1'b0;
    step();

    // 5: reload dropped while a result is pending, honoured once drained
    bus.out_ready = 1'b0;
    drive(6'd0);
    step();
    bus.in_valid = 1'b0;
    cfg_reload   = 1'b1;
    step();
    cfg_reload = 1'b0;
    check("t5_drop_running", running, 1);
    check("t5_drop_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    step();
    check("t5_drained", bus.out_valid, 0);
    cfg_reload = 1'b1;
    step();
    cfg_reload = 1'b0;
    check("t5_reload_running", running, 0);
    check("t5_reload_in_ready", bus.in_ready, 0);
    cfg_write(0, 1, 2, 1'b0, 1'b1);
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    check("t5_rerun", running, 1);
    for (int i = 0; i < 3; i++) begin
      drive(t5_idx[i]);
      step();
      check("t5_ch0", bus.out_word, {14'd0, t5_exp[i]});
    end
    bus.in_valid = 1'b0;
    step();
    check("t5_cnt_model", lookup_cnt, exp_cnt);

    // 6: reset mid-stream, then counter wrap
    drive(6'd1);
    step();
    drive(6'd6);
    step();
    rst_n = 1'b0;
    clear_model();
    step();
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_out_word", bus.out_word, 0);
    check("t6_running", running, 0);
    check("t6_cnt", lookup_cnt, 0);
    check("t6_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(6'(i * 31 + 1));
      step();
      check("t6_tables_zero", bus.out_word, 0);
    end
    bus.in_valid = 1'b0;
    step();
    dut.lookup_cnt_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    drive(6'd5);
    step();
    check("t6_cnt_max", lookup_cnt, 32'hFFFF_FFFF);
    drive(6'd9);
    step();
    check("t6_cnt_wrap", lookup_cnt, 0);
    bus.in_valid = 1'b0;
    step();

    // Out-of-range channel writes on a 5-channel bank change nothing
    cfg2_we = 1'b1; cfg2_ch = 3'd5; cfg2_addr = 6'd3; cfg2_data = 2'd3;
    step();
    cfg2_ch = 3'd7;
    step();
    cfg2_ch = 3'd4; cfg2_addr = 6'd5; cfg2_data = 2'd1;
    step();
    cfg2_we = 1'b0;
    cfg2_done = 1'b1;
    step();
    cfg2_done = 1'b0;
    check("t4b_running", running2, 1);
    bus2.out_ready = 1'b1;
    bus2.in_word = {6'd5, 6'd3, 6'd3, 6'd3, 6'd3};
    bus2.in_valid = 1'b1;
    step();
    check("t4b_in_range", bus2.out_word, 10'h100);
    bus2.in_word = {6'd3, 6'd3, 6'd3, 6'd3, 6'd3};
    step();
    check("t4b_oob_ignored", bus2.out_word, 0);
    bus2.in_valid = 1'b0;
    step();
    check("t4b_drained", bus2.out_valid, 0);
    check("t4b_cnt", lookup_cnt2, 2);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
